// File: rtl/frm_hyst_meter.sv
// Per-frame brightness meter: sums pixel gray levels between vsync edges and
// reports a hysteretic bright flag once frame geometry has locked.
module frm_hyst_meter #(
    parameter int HP     = 1920,
    parameter int VP     = 1080,
    parameter int TH_HI  = HP * VP * 128,
    parameter int TH_LO  = HP * VP * 96,
    parameter int LOCK_N = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       vs_i,
    input  logic       de_i,
    input  logic [7:0] wd_i,
    output logic       rx_o,
    output logic       lock_o,
    output logic [7:0] bad_o
);

    localparam int NPIX = HP * VP;
    localparam int SW   = $clog2(NPIX * 255 + 1) + 1;
    localparam int SWP  = SW + 1;
    localparam int PW   = $clog2(NPIX + 2);

    localparam logic [SW-1:0] TH_HI_S   = SW'(TH_HI);
    localparam logic [SW-1:0] TH_LO_S   = SW'(TH_LO);
    localparam logic [PW-1:0] PCNT_FULL = PW'(NPIX);
    localparam logic [PW-1:0] PCNT_MAX  = PW'(NPIX + 1);
    localparam logic [3:0]    LOCK_W    = 4'(LOCK_N);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [3:0]    gcnt_q, gcnt_d;
    logic [7:0]    bad_q, bad_d;
    logic          vs_q, seen_q, seen_d;
    logic          bright_q, bright_d;
    logic          rx_q, rx_d;

    logic          frame_edge;
    logic          good;
    logic          eval;
    logic [SWP-1:0] sum_ext;
    logic [3:0]    gcnt_inc;

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        pcnt_d   = pcnt_q;
        gcnt_d   = gcnt_q;
        bad_d    = bad_q;
        seen_d   = seen_q;
        bright_d = bright_q;
        eval     = 1'b0;

        frame_edge = vs_i & ~vs_q;
        good       = (pcnt_q == PCNT_FULL);
        sum_ext    = {1'b0, sum_q} + SWP'(wd_i);
        gcnt_inc   = gcnt_q + 4'd1;

        if (frame_edge) begin
            // The edge-cycle pixel opens the new frame; the old totals are judged first.
            sum_d  = de_i ? SW'(wd_i) : '0;
            pcnt_d = PW'(de_i);
            seen_d = 1'b1;
            if (seen_q) begin
                if (good) begin
                    if (state_q == UNLOCKED) begin
                        gcnt_d = gcnt_inc;
                        if (gcnt_inc >= LOCK_W) begin
                            state_d = LOCKED;
                            eval    = 1'b1;
                        end
                    end else begin
                        eval = 1'b1;
                    end
                end else begin
                    state_d = UNLOCKED;
                    gcnt_d  = 4'd0;
                    bad_d   = (bad_q == 8'hFF) ? bad_q : bad_q + 8'd1;
                end
            end
        end else if (de_i) begin
            sum_d  = sum_ext[SW] ? '1 : sum_ext[SW-1:0];
            pcnt_d = (pcnt_q == PCNT_MAX) ? pcnt_q : pcnt_q + 1'b1;
        end

        if (eval) begin
            if (sum_q > TH_HI_S) begin
                bright_d = 1'b1;
            end else if (sum_q < TH_LO_S) begin
                bright_d = 1'b0;
            end
        end

        rx_d = bright_d & (state_d == LOCKED);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= UNLOCKED;
            sum_q    <= '0;
            pcnt_q   <= '0;
            gcnt_q   <= 4'd0;
            bad_q    <= 8'd0;
            vs_q     <= 1'b0;
            seen_q   <= 1'b0;
            bright_q <= 1'b0;
            rx_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            pcnt_q   <= pcnt_d;
            gcnt_q   <= gcnt_d;
            bad_q    <= bad_d;
            vs_q     <= vs_i;
            seen_q   <= seen_d;
            bright_q <= bright_d;
            rx_q     <= rx_d;
        end
    end

    assign rx_o   = rx_q;
    assign lock_o = (state_q == LOCKED);
    assign bad_o  = bad_q;

endmodule

// File: tb/tb_frm_hyst_meter.sv
// Randomized frame stimulus against a frame-level reference model; expected
// outputs are queued at each frame edge and checked by an independent monitor.
module tb_frm_hyst_meter;

    localparam int HP     = 4;
    localparam int VP     = 2;
    localparam int NPIX   = HP * VP;
    localparam int TH_HI  = 1024;
    localparam int TH_LO  = 768;
    localparam int LOCK_N = 2;

    logic       clk    = 1'b0;
    logic       rst_ni = 1'b1;
    logic       vs_i   = 1'b0;
    logic       de_i   = 1'b0;
    logic [7:0] wd_i   = 8'd0;
    logic       rx_o;
    logic       lock_o;
    logic [7:0] bad_o;

    frm_hyst_meter #(
        .HP(HP), .VP(VP), .TH_HI(TH_HI), .TH_LO(TH_LO), .LOCK_N(LOCK_N)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .vs_i  (vs_i),
        .de_i  (de_i),
        .wd_i  (wd_i),
        .rx_o  (rx_o),
        .lock_o(lock_o),
        .bad_o (bad_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_edge   = 0;

    logic [9:0] exp_q[$];
    logic [9:0] cur_exp = 10'd0;

    // Frame-level reference state
    bit m_seen, m_prev_vs, m_locked, m_bright;
    int m_gcnt, m_bad, m_sum, m_cnt;

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got rx=%0d lock=%0d bad=%0d want rx=%0d lock=%0d bad=%0d",
                     name, $time, act[9], act[8], act[7:0], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic model_reset();
        m_seen = 0; m_prev_vs = 0; m_locked = 0; m_bright = 0;
        m_gcnt = 0; m_bad = 0; m_sum = 0; m_cnt = 0;
    endtask

    task automatic model_frame_end();
        if (m_cnt == NPIX) begin
            if (!m_locked) begin
                m_gcnt++;
                if (m_gcnt >= LOCK_N) m_locked = 1;
            end
            if (m_locked) begin
                if (m_sum > TH_HI) m_bright = 1;
                else if (m_sum < TH_LO) m_bright = 0;
            end
        end else begin
            m_locked = 0;
            m_gcnt   = 0;
            if (m_bad < 255) m_bad++;
        end
        exp_q.push_back({m_bright & m_locked, m_locked, 8'(m_bad)});
    endtask

    task automatic drive(input bit v, input bit d, input int wd);
        @(negedge clk);
        vs_i = v;
        de_i = d;
        wd_i = 8'(wd);
        if (v && !m_prev_vs) begin
            if (m_seen) model_frame_end();
            m_seen = 1;
            m_sum  = d ? wd : 0;
            m_cnt  = d ? 1 : 0;
        end else if (d) begin
            m_sum += wd;
            m_cnt++;
        end
        m_prev_vs = v;
    endtask

    // One frame: vsync high for 1..4 cycles (pixels may fall inside it),
    // npix pixels with random gaps, then a blank cycle with vsync low.
    task automatic frame(input int npix, input int lo, input int hi,
                         input bit edge_pix, input int edge_wd);
        int vs_len;
        int c;
        int left;
        bit v;
        bit d;
        int wd;
        vs_len = int'($urandom_range(1, 4));
        c      = 0;
        left   = npix;
        while (left > 0 || c < vs_len) begin
            v = (c < vs_len);
            if (c == 0) d = edge_pix && (left > 0);
            else        d = (left > 0) && ($urandom_range(0, 3) != 0);
            wd = (c == 0) ? edge_wd : int'($urandom_range(lo, hi));
            drive(v, d, wd);
            if (d) left--;
            c++;
        end
        drive(0, 0, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_reset", {rx_o, lock_o, bad_o}, 10'd0);
        exp_q.delete();
        cur_exp = 10'd0;
        model_reset();
        @(negedge clk);
        vs_i = 1'b0; de_i = 1'b0; wd_i = 8'd0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_ni) begin
            if (exp_q.size() > 0) begin
                cur_exp = exp_q.pop_front();
                n_edge++;
                $display("edge %0d rx=%0d lock=%0d bad=%0d", n_edge, rx_o, lock_o, bad_o);
                chk("edge", {rx_o, lock_o, bad_o}, cur_exp);
            end else begin
                chk("hold", {rx_o, lock_o, bad_o}, cur_exp);
            end
        end
    end

    initial begin
        model_reset();
        #2 rst_ni = 1'b0;
        #1 chk("reset_state", {rx_o, lock_o, bad_o}, 10'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        // Lock on bright frames
        repeat (5) frame(NPIX, 200, 200, 0, 0);
        // Hysteresis band, exact thresholds, then dark
        repeat (2) frame(NPIX, 110, 110, $urandom_range(0, 1), 110);
        frame(NPIX, 128, 128, 0, 0);
        frame(NPIX, 96, 96, 0, 0);
        repeat (2) frame(NPIX, 90, 90, 0, 0);
        frame(NPIX, 96, 96, 0, 0);
        // Relight, short frame, relock
        repeat (2) frame(NPIX, 200, 200, 0, 0);
        frame(NPIX - 1, 200, 200, 0, 0);
        repeat (3) frame(NPIX, 200, 200, 0, 0);
        // Dark, then a frame whose edge-cycle pixel carries it over TH_HI
        repeat (2) frame(NPIX, 90, 90, 0, 0);
        frame(NPIX, 112, 112, 1, 255);
        frame(NPIX, 112, 112, 0, 0);
        frame(NPIX, 90, 90, 1, 90);

        // Randomized frames around the threshold band
        for (int i = 0; i < 40; i++) begin
            int n;
            int lo;
            n  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(6, 12)) : NPIX;
            lo = int'($urandom_range(80, 140));
            frame(n, lo, lo + 20, $urandom_range(0, 1), int'($urandom_range(0, 255)));
        end

        // Saturate the bad-frame counter
        for (int i = 0; i < 300; i++) frame(NPIX - 1, 0, 255, 0, 0);

        // Reset mid-frame; the following edge is a first edge again
        drive(1, 0, 0);
        drive(0, 1, 77);
        drive(0, 1, 78);
        pulse_reset();
        repeat (4) frame(NPIX, 150, 160, 0, 0);
        frame(NPIX + 1, 150, 160, 0, 0);
        repeat (3) frame(NPIX, 150, 160, 0, 0);

        repeat (4) @(negedge clk);
        chk("drain", 10'(exp_q.size()), 10'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
